laser_frame_feeder: RTL and testbench

- Upstream stage of the two-circle laser solver.
- Accepts target points (4-bit X/Y) from a valid/ready source and buffers one complete frame of NUM_POINTS points.
- Streams the frame to the solver as an unbroken burst, one point per cycle, then holds off the next frame until the solver pulses DONE.
- Guarantees the solver sees gap-free, frame-aligned point streams.

---
 rtl/laser_pkg.sv | 18 +
 rtl/laser_point_ram.sv | 37 +++
 rtl/laser_frame_feeder.sv | 186 ++++++++++++++++++
 tb/tb_laser_frame_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// laser_pkg: types and defaults shared by the laser frame feeder and the solver.
package laser_pkg;

    localparam int LASER_CW         = 4;
    localparam int LASER_NUM_POINTS = 40;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [LASER_CW-1:0] x;
        logic [LASER_CW-1:0] y;
    } point_t;

endpackage

// File: rtl/laser_point_ram.sv
// laser_point_ram: one frame of point storage, one write port, registered read port.
// The read register holds its value when no read is issued so the solver-facing
// X/Y keep the last streamed point.
module laser_point_ram
    import laser_pkg::*;
#(
    parameter int DEPTH = LASER_NUM_POINTS,
    parameter int DW    = 2 * LASER_CW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Storage write; contents are never cleared
    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Registered read, holds between reads
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/laser_frame_feeder.sv
// laser_frame_feeder: buffers one frame of points and streams it to the solver
// as a gap-free burst, then waits for the solver's DONE before the next burst.
// Optional macro LASER_FEEDER_DOUBLE_BUF_EN: two ping-pong banks so the next
// frame fills while the current one streams / waits for DONE.
//
// state     | meaning
// FILL      | single bank: accepting points; double bank: reader idle until a bank is full
// STREAM    | reading the frame out, one point per cycle
// WAIT_DONE | burst sent, waiting for solver DONE
module laser_frame_feeder
    import laser_pkg::*;
#(
    parameter int NUM_POINTS = LASER_NUM_POINTS,
    parameter int CW         = LASER_CW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    input  logic [CW-1:0] i_in_x,
    input  logic [CW-1:0] i_in_y,
    output logic          o_in_ready,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_out_valid,
    output logic          o_out_first,
    output logic          o_out_last,
    input  logic          i_done,
    output logic [7:0]    o_frame_cnt,
    output logic          o_err_early_done
);

    localparam int            IW       = $clog2(NUM_POINTS);
    localparam int            DW       = 2 * CW;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_POINTS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_wr_idx, r_rd_idx, w_rd_idx_nxt, w_rd_addr;
    logic          w_in_ready, w_acc, w_acc_last;
    logic          w_rd_en, w_done_ok, w_fill_start, w_next_ready;
    logic          r_out_valid, r_out_first, r_out_last;
    logic [7:0]    r_frame_cnt;
    logic          r_err_early;
    logic [DW-1:0] w_rd_data;

    assign w_acc      = i_in_valid & w_in_ready;
    assign w_acc_last = w_acc & (r_wr_idx == LAST_IDX);

    // Write index advances on every accepted point, wraps at the frame end
    always_ff @(posedge i_clk) begin
        if (i_rst)      r_wr_idx <= '0;
        else if (w_acc) r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_ONE;
    end

`ifdef LASER_FEEDER_DOUBLE_BUF_EN
    logic [1:0]    r_full;
    logic          r_wr_bank, r_rd_bank, r_out_bank, w_rd_bank;
    logic [DW-1:0] w_bank_q [2];

    assign w_in_ready   = ~r_full[r_wr_bank];
    // A bank completing this very cycle counts as full so no cycle is lost
    assign w_fill_start = r_full[r_rd_bank] | (w_acc_last & (r_wr_bank == r_rd_bank));
    assign w_next_ready = r_full[~r_rd_bank] | (w_acc_last & (r_wr_bank != r_rd_bank));
    assign w_rd_bank    = w_done_ok ? ~r_rd_bank : r_rd_bank;
    assign w_rd_data    = w_bank_q[r_out_bank];

    // Bank occupancy flags and ping-pong pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_out_bank <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_acc_last && r_wr_bank == 1'(b))     r_full[b] <= 1'b1;
                else if (w_done_ok && r_rd_bank == 1'(b)) r_full[b] <= 1'b0;
            end
            if (w_acc_last) r_wr_bank  <= ~r_wr_bank;
            if (w_done_ok)  r_rd_bank  <= ~r_rd_bank;
            if (w_rd_en)    r_out_bank <= w_rd_bank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        laser_point_ram #(.DEPTH(NUM_POINTS), .DW(DW), .AW(IW)) u_ram (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (w_acc && (r_wr_bank == 1'(b))),
            .i_wr_addr (r_wr_idx),
            .i_wr_data ({i_in_x, i_in_y}),
            .i_rd_en   (w_rd_en && (w_rd_bank == 1'(b))),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_bank_q[b])
        );
    end
`else
    assign w_in_ready   = (r_state == FILL);
    assign w_fill_start = w_acc_last;
    assign w_next_ready = 1'b0;

    laser_point_ram #(.DEPTH(NUM_POINTS), .DW(DW), .AW(IW)) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_acc),
        .i_wr_addr (r_wr_idx),
        .i_wr_data ({i_in_x, i_in_y}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= FILL;
        else       r_state <= w_state_nxt;
    end

    // Next state, read sequencing and DONE acceptance
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_idx_nxt = r_rd_idx;
        w_rd_addr    = r_rd_idx;
        w_rd_en      = 1'b0;
        w_done_ok    = 1'b0;
        case (r_state)
            FILL: begin
                if (w_fill_start) w_state_nxt = STREAM;
            end
            STREAM: begin
                w_rd_en = 1'b1;
                if (r_rd_idx == LAST_IDX) begin
                    w_rd_idx_nxt = '0;
                    w_state_nxt  = WAIT_DONE;
                end else begin
                    w_rd_idx_nxt = r_rd_idx + IDX_ONE;
                end
            end
            WAIT_DONE: begin
                if (i_done) begin
                    w_done_ok = 1'b1;
                    if (w_next_ready) begin
                        // Issue point 0 of the other bank in the DONE cycle itself
                        w_rd_en      = 1'b1;
                        w_rd_addr    = '0;
                        w_rd_idx_nxt = IDX_ONE;
                        w_state_nxt  = STREAM;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Read index, output flags aligned with the registered read, counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_cnt <= '0;
            r_err_early <= 1'b0;
        end else begin
            r_rd_idx    <= w_rd_idx_nxt;
            r_out_valid <= w_rd_en;
            r_out_first <= w_rd_en && (w_rd_addr == '0);
            r_out_last  <= w_rd_en && (w_rd_addr == LAST_IDX);
            if (w_done_ok) r_frame_cnt <= r_frame_cnt + 8'd1;
            if (i_done && (r_state != WAIT_DONE)) r_err_early <= 1'b1;
        end
    end

    assign o_in_ready       = w_in_ready;
    assign o_x              = w_rd_data[DW-1:CW];
    assign o_y              = w_rd_data[CW-1:0];
    assign o_out_valid      = r_out_valid;
    assign o_out_first      = r_out_first;
    assign o_out_last       = r_out_last;
    assign o_frame_cnt      = r_frame_cnt;
    assign o_err_early_done = r_err_early;

endmodule

// File: tb/tb_laser_frame_feeder.sv
// tb_laser_frame_feeder: directed sequence with randomized points and valid
// patterns, checked every cycle against a frame-level reference model.
module tb_laser_frame_feeder;

    localparam int N = 40;
`ifdef LASER_FEEDER_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       done = 1'b0;
    logic [3:0] in_x = 4'd0;
    logic [3:0] in_y = 4'd0;
    logic       o_in_ready, o_out_valid, o_out_first, o_out_last, o_err_early_done;
    logic [3:0] o_x, o_y;
    logic [7:0] o_frame_cnt;

    always #5 clk = ~clk;

    laser_frame_feeder dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_in_valid       (in_valid),
        .i_in_x           (in_x),
        .i_in_y           (in_y),
        .o_in_ready       (o_in_ready),
        .o_x              (o_x),
        .o_y              (o_y),
        .o_out_valid      (o_out_valid),
        .o_out_first      (o_out_first),
        .o_out_last       (o_out_last),
        .i_done           (done),
        .o_frame_cnt      (o_frame_cnt),
        .o_err_early_done (o_err_early_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: partial frame being filled, completed frames (flat, N per
    // frame, front frame is the one bursting or awaiting DONE), burst start cycle.
    logic [7:0] fill_q[$];
    logic [7:0] pts[$];
    int cyc = 0;
    int start = 0;
    bit active = 0;
    bit armed = 0;
    int m_cnt = 0;
    bit m_err = 0;

    int feed_left = 0;
    int pt_i = 0;
    bit use_ramp = 0;
    int auto_dd = -1;
    int dlen = 1;
    int done_sched = -1000;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_point();
        int r;
        if (use_ramp) begin
            r = pt_i % N;
            in_x = 4'(r);
            in_y = 4'(N - 1 - r);
        end else begin
            in_x = 4'($urandom_range(0, 15));
            in_y = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_outputs();
        bit ev;
        int j;
        ev = active && (cyc >= start) && (cyc < start + N);
        j  = cyc - start;
        chk("in_ready",  16'(o_in_ready),  16'((pts.size() / N) < NB));
        chk("out_valid", 16'(o_out_valid), 16'(ev));
        chk("out_first", 16'(o_out_first), 16'(ev && j == 0));
        chk("out_last",  16'(o_out_last),  16'(ev && j == N - 1));
        if (ev) begin
            chk("x", 16'(o_x), 16'(pts[j][7:4]));
            chk("y", 16'(o_y), 16'(pts[j][3:0]));
        end
        chk("frame_cnt", 16'(o_frame_cnt), 16'(m_cnt));
        chk("err_early", 16'(o_err_early_done), 16'(m_err));
    endtask

    // One clock: note what the DUT will sample, advance, update model, check
    task automatic tick(output bit acc);
        bit rs, dn;
        int k;
        logic [7:0] p;
        rs  = rst;
        dn  = !rst && done;
        acc = !rst && in_valid && (o_in_ready === 1'b1);
        p   = {in_x, in_y};
        k   = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            fill_q.delete();
            pts.delete();
            active = 0;
            m_cnt  = 0;
            m_err  = 0;
            armed  = 1;
        end else if (armed) begin
            if (acc) begin
                fill_q.push_back(p);
                pt_i++;
                if (fill_q.size() == N) begin
                    for (int i = 0; i < N; i++) pts.push_back(fill_q[i]);
                    fill_q.delete();
                    if (!active) begin
                        active = 1;
                        start  = k + 2;
                    end
                end
            end
            if (dn) begin
                if (active && k >= start + N - 1) begin
                    for (int i = 0; i < N; i++) void'(pts.pop_front());
                    m_cnt = (m_cnt + 1) % 256;
                    if (pts.size() >= N) start = k + 1;
                    else active = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
        if (armed) check_outputs();
    endtask

    task automatic run(input int ncyc, input int vmode);
        bit acc;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = (feed_left > 0) &&
                       (vmode == 1 || (vmode == 2 && $urandom_range(0, 1) == 1));
            done = (cyc >= done_sched) && (cyc < done_sched + dlen);
            tick(acc);
            if (acc) begin
                feed_left--;
                next_point();
            end
            if (auto_dd >= 0 && o_out_last === 1'b1) done_sched = cyc + auto_dd;
        end
        in_valid = 1'b0;
        done     = 1'b0;
    endtask

    task automatic do_reset(input int n);
        bit acc;
        rst = 1'b1;
        in_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
        rst = 1'b0;
    endtask

    task automatic wait_start();
        int g;
        g = 0;
        while (!(active && cyc >= start) && g < 300) begin
            run(1, 1);
            g++;
        end
        chk("burst_started", 16'(active && cyc >= start), 16'd1);
    endtask

    initial begin
        do_reset(3);

        // Ramp frame (i, 39-i), back-to-back
        use_ramp = 1;
        pt_i = 0;
        next_point();
        feed_left = N;
        auto_dd = -1;
        run(2 * N + 4, 1);
        chk("hold_x", 16'(o_x), 16'd7);
        chk("hold_y", 16'(o_y), 16'd0);
        done_sched = cyc + 2;
        dlen = 1;
        run(4, 0);
        chk("cnt_first", 16'(o_frame_cnt), 16'd1);

        // Random points with IN_VALID toggling
        use_ramp = 0;
        next_point();
        feed_left = N;
        auto_dd = 3;
        run(220, 2);

        // Source holds IN_VALID through STREAM/WAIT_DONE
        next_point();
        feed_left = N + 1;
        auto_dd = 4;
        run(130, 1);

        // Early DONE at burst point 20, then a 3-cycle DONE
        auto_dd = -1;
        feed_left = N - 1;
        wait_start();
        done_sched = start + 20;
        dlen = 1;
        run(N + 2, 0);
        chk("err_sticky", 16'(o_err_early_done), 16'd1);
        done_sched = cyc + 1;
        dlen = 3;
        run(6, 0);

        // Reset on burst point 10, then a fresh frame
        dlen = 1;
        next_point();
        feed_left = N;
        wait_start();
        run(10, 0);
        do_reset(1);
        next_point();
        feed_left = N;
        auto_dd = 2;
        run(100, 1);
        chk("cnt_after_rst", 16'(o_frame_cnt), 16'd1);

        // Two random frames, random DONE delay and length
        next_point();
        feed_left = 2 * N;
        auto_dd = $urandom_range(0, 6);
        dlen = $urandom_range(1, 3);
        run(420, 2);

`ifdef LASER_FEEDER_DOUBLE_BUF_EN
        // 80 points continuous, DONE 5 cycles after each OUT_LAST
        do_reset(2);
        next_point();
        feed_left = 2 * N;
        auto_dd = 5;
        dlen = 1;
        run(200, 1);
        chk("cnt_two", 16'(o_frame_cnt), 16'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
